// File: rtl/hazard_scoreboard.sv
// Purpose: ID-stage hazard scoreboard; tracks in-flight rd writes with per-register latency counters.
// Latency: stall/issue/flush are combinational (0 cycles) from current counters and ID inputs.
// Backpressure: stall holds PC and IF/ID; a redirect from EX kills the ID instruction instead of stalling.
//
// Ports:
//   clk, rst_n                        clock (rising edge), asynchronous active-low reset
//   id_valid, id_rs1/2, id_rs1/2_used source operands of the instruction in ID
//   id_rd, id_rd_we, id_lat           destination and cycles until rd is forwardable
//   ex_redirect                       taken branch/jump resolved in EX this cycle
//   stall, id_fire, flush_if, flush_id pipeline controls
//   pending                           per-register "result not yet forwardable" flags
//   stall_cycles                      free-running count of stalled cycles (wraps)
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int LAT_W    = 3,
    parameter int MAX_LAT  = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_rd_we,
    input  logic [LAT_W-1:0]    id_lat,
    input  logic                ex_redirect,
    output logic                stall,
    output logic                id_fire,
    output logic                flush_if,
    output logic                flush_id,
    output logic [NUM_REGS-1:0] pending,
    output logic [31:0]         stall_cycles
);

    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] cnt_d [NUM_REGS];
    logic [31:0]      stall_cycles_q;
    logic [31:0]      stall_cycles_d;

    logic [LAT_W-1:0] eff_lat;
    logic             rs1_hz;
    logic             rs2_hz;
    logic             raw_hz;
    logic             waw_hz;

    // Hazard detection and pipeline controls.
    always_comb begin
        eff_lat = (id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : id_lat;

        rs1_hz = id_rs1_used && (id_rs1 != '0) && (cnt_q[id_rs1] != '0);
        rs2_hz = id_rs2_used && (id_rs2 != '0) && (cnt_q[id_rs2] != '0);
        raw_hz = id_valid && (rs1_hz || rs2_hz);

        // A younger write must not land before an older in-flight one to the same rd.
        waw_hz = id_valid && id_rd_we && (id_rd != '0) && (cnt_q[id_rd] > eff_lat);

        // The ID instruction is squashed by a redirect, so it must never hold the front end.
        stall    = (raw_hz || waw_hz) && !ex_redirect;
        id_fire  = id_valid && !stall && !ex_redirect;
        flush_if = ex_redirect;
        flush_id = ex_redirect || stall;
    end

    // Counter next-state: a fresh issue reloads, otherwise count down to zero.
    // Redirects leave counters alone because older issued instructions still complete.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        cnt_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (id_fire && id_rd_we && (id_rd == REG_AW'(r)) && (eff_lat != '0)) begin
                cnt_d[r] = eff_lat;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
        stall_cycles_d = stall ? (stall_cycles_q + 32'd1) : stall_cycles_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            pending[r] = (cnt_q[r] != '0);
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule
